// File: rtl/mem_arb.sv
// Two-port arbiter in front of a single-port synchronous RAM with a registered
// command stage. Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties, else port A wins.
module mem_arb #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_read_write,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  // Handshake: a port raises req with we/addr/wdata and holds them until gnt is
  // seen high in the same cycle; that cycle is the acceptance, after which the
  // port may drop or change its request. Reads answer with a one-cycle rvalid
  // two cycles after acceptance, in acceptance order.

  logic w_a_sel;
  logic w_b_sel;
  logic w_a_wins_tie;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last_a;  // 1 = port A held the most recent grant

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_a <= 1'b0;
    end else if (w_a_sel) begin
      r_last_a <= 1'b1;
    end else if (w_b_sel) begin
      r_last_a <= 1'b0;
    end
  end

  assign w_a_wins_tie = ~r_last_a;
`else
  assign w_a_wins_tie = 1'b1;
`endif

  assign w_a_sel = rst_n & a_req & (~b_req | w_a_wins_tie);
  assign w_b_sel = rst_n & b_req & ~w_a_sel;
  assign a_gnt   = w_a_sel;
  assign b_gnt   = w_b_sel;

  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_data_in;
  logic                  r_ram_rw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_addr    <= '0;
      r_ram_data_in <= '0;
      r_ram_rw      <= 1'b0;
    end else if (w_a_sel) begin
      r_ram_addr    <= a_addr;
      r_ram_data_in <= a_wdata;
      r_ram_rw      <= a_we;
    end else if (w_b_sel) begin
      r_ram_addr    <= b_addr;
      r_ram_data_in <= b_wdata;
      r_ram_rw      <= b_we;
    end else begin
      r_ram_rw      <= 1'b0;
    end
  end

  assign ram_addr       = r_ram_addr;
  assign ram_data_in    = r_ram_data_in;
  assign ram_read_write = r_ram_rw;

  // Read tag pipeline: stage 1 lines up with the RAM command cycle, stage 2
  // with the cycle the RAM presents its registered read data.
  logic r_t1_vld;
  logic r_t1_is_b;
  logic r_t2_vld;
  logic r_t2_is_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t1_vld  <= 1'b0;
      r_t1_is_b <= 1'b0;
      r_t2_vld  <= 1'b0;
      r_t2_is_b <= 1'b0;
    end else begin
      r_t1_vld  <= (w_a_sel & ~a_we) | (w_b_sel & ~b_we);
      r_t1_is_b <= w_b_sel;
      r_t2_vld  <= r_t1_vld;
      r_t2_is_b <= r_t1_is_b;
    end
  end

  assign a_rvalid = r_t2_vld & ~r_t2_is_b;
  assign b_rvalid = r_t2_vld & r_t2_is_b;
  assign rdata    = r_t2_vld ? ram_data_out : '0;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: RAM model, directed scenarios plus random traffic, with a
// grant/RAM-command reference model and an in-order read-data scoreboard.
module tb_mem_arb;
  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in;
  logic          ram_read_write;
  logic [DW-1:0] ram_data_out = '0;

  mem_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid),
    .rdata(rdata), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_read_write(ram_read_write), .ram_data_out(ram_data_out)
  );

  // ---------------- clock / reset / RAM model ----------------
  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (ram_read_write) mem[ram_addr] <= ram_data_in;
    ram_data_out <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] exp_q[$];
  logic          exp_port_q[$];   // 1 = port B
  int            exp_cyc_q[$];
  logic          exp_rw = 1'b0;
  logic [AW-1:0] exp_ram_addr = '0;
  logic [DW-1:0] exp_wdata = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic          exp_last_a = 1'b0;
`endif
  logic          tie_a, exp_a_g, exp_b_g;
  logic [DW-1:0] m_d;
  logic          m_p;
  int            m_c;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / reference model ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_ctrl", {a_gnt, b_gnt, a_rvalid, b_rvalid, ram_read_write}, 0);
      check("rst_rdata", rdata, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_ram_din", ram_data_in, 0);
      exp_q.delete();
      exp_port_q.delete();
      exp_cyc_q.delete();
      exp_rw = 1'b0;
      exp_ram_addr = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_last_a = 1'b0;
`endif
    end else begin
      check("rvalid_onehot", a_rvalid & b_rvalid, 0);
      if (a_rvalid || b_rvalid) begin
        if (exp_q.size() == 0) begin
          check("rvalid_unexpected", {a_rvalid, b_rvalid}, 0);
        end else begin
          m_d = exp_q.pop_front();
          m_p = exp_port_q.pop_front();
          m_c = exp_cyc_q.pop_front();
          check("rvalid_port", {a_rvalid, b_rvalid}, m_p ? 2'b01 : 2'b10);
          check("rdata", rdata, m_d);
          check("rvalid_latency", cyc, m_c);
        end
      end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
        check("rvalid_missing", {a_rvalid, b_rvalid}, exp_port_q[0] ? 2'b01 : 2'b10);
        void'(exp_q.pop_front());
        void'(exp_port_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end

      check("ram_rw", ram_read_write, exp_rw);
      check("ram_addr", ram_addr, exp_ram_addr);
      if (exp_rw) begin
        check("ram_din", ram_data_in, exp_wdata);
        ref_mem[exp_ram_addr] = exp_wdata;
      end

`ifdef MEM_ARB_ROUND_ROBIN_EN
      tie_a = !exp_last_a;
`else
      tie_a = 1'b1;
`endif
      exp_a_g = a_req && (!b_req || tie_a);
      exp_b_g = b_req && !exp_a_g;
      check("a_gnt", a_gnt, exp_a_g);
      check("b_gnt", b_gnt, exp_b_g);

      exp_rw = 1'b0;
      if (exp_a_g) begin
        exp_ram_addr = a_addr;
        exp_rw = a_we;
        exp_wdata = a_wdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_last_a = 1'b1;
`endif
        if (!a_we) begin
          exp_q.push_back(ref_mem[a_addr]);
          exp_port_q.push_back(1'b0);
          exp_cyc_q.push_back(cyc + 2);
        end
      end else if (exp_b_g) begin
        exp_ram_addr = b_addr;
        exp_rw = b_we;
        exp_wdata = b_wdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_last_a = 1'b0;
`endif
        if (!b_we) begin
          exp_q.push_back(ref_mem[b_addr]);
          exp_port_q.push_back(1'b1);
          exp_cyc_q.push_back(cyc + 2);
        end
      end
    end
  end

  // ---------------- driver tasks (called just after a rising edge) ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic req_a(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = data;
  endtask

  task automatic req_b(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = data;
  endtask

  task automatic wait_a_gnt();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!a_gnt && n < 50);
    if (!a_gnt) check("a_gnt_timeout", a_gnt, 1);
    @(posedge clk);
    #1;
    a_req = 1'b0;
  endtask

  task automatic wait_b_gnt();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b_gnt && n < 50);
    if (!b_gnt) check("b_gnt_timeout", b_gnt, 1);
    @(posedge clk);
    #1;
    b_req = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic ga, gb;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    idle(3);

    // release reset with a request already waiting: grant in the first cycle
    rst_n = 1'b1;
    req_a(1'b1, 12'h010, 32'hDEADBEEF);
    wait_a_gnt();
    req_a(1'b0, 12'h010, '0);
    wait_a_gnt();

    idle(10);

    // both ports reading every cycle, then A drops out
    req_a(1'b0, AW'($urandom_range(0, 15)), '0);
    req_b(1'b0, AW'($urandom_range(0, 15)), '0);
    repeat (6) begin
      @(negedge clk);
      ga = a_gnt; gb = b_gnt;
      @(posedge clk);
      #1;
      if (ga) a_addr = AW'($urandom_range(0, 15));
      if (gb) b_addr = AW'($urandom_range(0, 15));
    end
    a_req = 1'b0;
    wait_b_gnt();
    idle(3);

    // write from B immediately followed by read from A of the same word
    req_b(1'b1, 12'h020, 32'h00000005);
    @(posedge clk);
    #1;
    b_req = 1'b0;
    req_a(1'b0, 12'h020, '0);
    wait_a_gnt();
    idle(3);

    // reset in the cycle after a read grant: the read must vanish
    req_b(1'b0, 12'h020, '0);
    wait_b_gnt();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(4);

    // reset in the cycle after a write grant: the write must be aborted
    req_a(1'b1, 12'h030, 32'hCAFE0001);
    wait_a_gnt();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    req_b(1'b0, 12'h030, '0);
    wait_b_gnt();
    idle(3);

    // random traffic; requests held until granted
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      ga = a_gnt; gb = b_gnt;
      @(posedge clk);
      #1;
      if (!a_req || ga) begin
        a_req = ($urandom_range(0, 9) < 6);
        a_we = 1'($urandom_range(0, 1));
        a_addr = AW'($urandom_range(0, 15));
        a_wdata = $urandom;
      end
      if (!b_req || gb) begin
        b_req = ($urandom_range(0, 9) < 6);
        b_we = 1'($urandom_range(0, 1));
        b_addr = AW'($urandom_range(0, 15));
        b_wdata = $urandom;
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    idle(6);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
